// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
//   Bundle between the pipeline datapath and the hazard controller.
//
//   Datapath -> controller:
//     id_rs, id_rt              source registers of the instruction in ID
//     id_rs_valid, id_rt_valid  qualify id_rs/id_rt: the source is really read
//     ex_write_reg              destination of the instruction in EX (ID/EX)
//     ex_reg_write, ex_mem_read control bits of the instruction in EX (ID/EX)
//     redirect                  taken branch/jump resolved in EX this cycle
//     mem_busy                  data memory cannot complete this cycle
//     halt_in                   halt instruction has reached WB
//   Controller -> datapath:
//     pc_write_en, if_id_write_en  load enables for PC and IF/ID
//     if_id_flush                  load a NOP into IF/ID
//     zero_control_signals         bubble into ID/EX
//     pipe_hold                    freeze ID/EX, EX/MEM, MEM/WB
//     halted                       pipeline is stopped
//
//   There is no valid/ready handshake here: every signal is a level sampled
//   each cycle, and the *_valid bits only qualify the matching register field.
//   master = datapath side, slave = hazard controller side.
// -----------------------------------------------------------------------------
interface hazard_ctrl_if;
  logic [2:0] id_rs;
  logic [2:0] id_rt;
  logic       id_rs_valid;
  logic       id_rt_valid;
  logic [2:0] ex_write_reg;
  logic       ex_reg_write;
  logic       ex_mem_read;
  logic       redirect;
  logic       mem_busy;
  logic       halt_in;

  logic       pc_write_en;
  logic       if_id_write_en;
  logic       if_id_flush;
  logic       zero_control_signals;
  logic       pipe_hold;
  logic       halted;

  modport master (
    output id_rs, id_rt, id_rs_valid, id_rt_valid,
    output ex_write_reg, ex_reg_write, ex_mem_read,
    output redirect, mem_busy, halt_in,
    input  pc_write_en, if_id_write_en, if_id_flush,
    input  zero_control_signals, pipe_hold, halted
  );

  modport slave (
    input  id_rs, id_rt, id_rs_valid, id_rt_valid,
    input  ex_write_reg, ex_reg_write, ex_mem_read,
    input  redirect, mem_busy, halt_in,
    output pc_write_en, if_id_write_en, if_id_flush,
    output zero_control_signals, pipe_hold, halted
  );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller: load-use stall, branch/jump redirect flush,
//   data-memory wait hold and halt.
//
//   Parameters:
//     FLUSH_LEN    total bubble cycles per redirect (1..7)
//     STALL_CNT_W  width of stall_count
//   Ports:
//     clk          rising-edge clock
//     rst          asynchronous active-low reset
//     bus          hazard_ctrl_if.slave (datapath inputs, control outputs)
//     state        current FSM state (RUN=0, FLUSH=1, MEMWAIT=2, HALT=3)
//     stall_count  saturating count of cycles with the PC stalled (not in HALT)
//
//   Event priority in every state: halt_in > mem_busy > redirect > load_use.
//   Outputs are purely combinational from current state and inputs.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int FLUSH_LEN   = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  hazard_ctrl_if.slave           bus,
  output logic [1:0]             state,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    MEMWAIT = 2'd2,
    HALT    = 2'd3
  } state_e;

  // Number of FLUSH cycles that follow the redirect cycle itself.
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_LEN - 1);

  state_e                 state_q, state_d;
  logic [2:0]             flush_cnt_q, flush_cnt_d;
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

  logic rs_hit;
  logic rt_hit;
  logic load_use;

  assign rs_hit   = bus.id_rs_valid && (bus.id_rs == bus.ex_write_reg);
  assign rt_hit   = bus.id_rt_valid && (bus.id_rt == bus.ex_write_reg);
  assign load_use = bus.ex_mem_read && bus.ex_reg_write && (rs_hit || rt_hit);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      flush_cnt_q   <= 3'd0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    stall_count_d = stall_count_q;

    if (state_q == HALT) begin
      state_d = HALT;
    end else if (bus.halt_in) begin
      state_d = HALT;
    end else if (bus.mem_busy) begin
      // A flush interrupted by memory keeps its remaining count and resumes.
      state_d = (state_q == FLUSH) ? FLUSH : MEMWAIT;
    end else if (bus.redirect) begin
      // The redirect cycle is itself the first bubble.
      if (FLUSH_LEN > 1) begin
        state_d     = FLUSH;
        flush_cnt_d = FLUSH_RELOAD;
      end else begin
        state_d = RUN;
      end
    end else if (state_q == FLUSH) begin
      if (flush_cnt_q <= 3'd1) begin
        flush_cnt_d = 3'd0;
        state_d     = RUN;
      end else begin
        flush_cnt_d = flush_cnt_q - 3'd1;
        state_d     = FLUSH;
      end
    end else begin
      // RUN, or MEMWAIT with memory now free: load_use keeps us in RUN.
      state_d = RUN;
    end

    if (!bus.pc_write_en && (state_q != HALT) && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.pc_write_en          = 1'b1;
    bus.if_id_write_en       = 1'b1;
    bus.if_id_flush          = 1'b0;
    bus.zero_control_signals = 1'b0;
    bus.pipe_hold            = 1'b0;
    bus.halted               = 1'b0;

    if ((state_q == HALT) || bus.halt_in) begin
      bus.pc_write_en          = 1'b0;
      bus.if_id_write_en       = 1'b0;
      bus.zero_control_signals = 1'b1;
      bus.halted               = 1'b1;
    end else if (bus.mem_busy) begin
      bus.pc_write_en    = 1'b0;
      bus.if_id_write_en = 1'b0;
      bus.pipe_hold      = 1'b1;
    end else if (bus.redirect || (state_q == FLUSH)) begin
      // FLUSH ignores load_use: the instruction in ID is being discarded.
      bus.if_id_flush          = 1'b1;
      bus.zero_control_signals = 1'b1;
    end else if (load_use) begin
      bus.pc_write_en          = 1'b0;
      bus.if_id_write_en       = 1'b0;
      bus.zero_control_signals = 1'b1;
    end
  end

  assign state       = state_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   dut_a: FLUSH_LEN=3, STALL_CNT_W=4 (multi-cycle flush, saturation)
//   dut_b: defaults (FLUSH_LEN=1, STALL_CNT_W=16), inputs mirrored from dut_a
//   Expected output vectors {pc_we, ifid_we, flush, zero_ctl, hold, halted,
//   state} are queued at drive time and popped when sampled 2 ns later.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if if_a ();
  hazard_ctrl_if if_b ();

  logic [1:0]  state_a, state_b;
  logic [3:0]  sc_a;
  logic [15:0] sc_b;

  hazard_ctrl #(.FLUSH_LEN(3), .STALL_CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave), .state(state_a), .stall_count(sc_a)
  );

  hazard_ctrl dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave), .state(state_b), .stall_count(sc_b)
  );

  assign if_b.id_rs        = if_a.id_rs;
  assign if_b.id_rt        = if_a.id_rt;
  assign if_b.id_rs_valid  = if_a.id_rs_valid;
  assign if_b.id_rt_valid  = if_a.id_rt_valid;
  assign if_b.ex_write_reg = if_a.ex_write_reg;
  assign if_b.ex_reg_write = if_a.ex_reg_write;
  assign if_b.ex_mem_read  = if_a.ex_mem_read;
  assign if_b.redirect     = if_a.redirect;
  assign if_b.mem_busy     = if_a.mem_busy;
  assign if_b.halt_in      = if_a.halt_in;

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [5:0] O_RUN = 6'b110000;
  localparam logic [5:0] O_BUB = 6'b000100;
  localparam logic [5:0] O_FLS = 6'b111100;
  localparam logic [5:0] O_HLD = 6'b000010;
  localparam logic [5:0] O_HLT = 6'b000101;

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_FLS = 2'd1;
  localparam logic [1:0] S_MW  = 2'd2;
  localparam logic [1:0] S_HLT = 2'd3;

  // events {halt_in, mem_busy, redirect}
  localparam logic [2:0] E_NO = 3'b000;
  localparam logic [2:0] E_RD = 3'b001;
  localparam logic [2:0] E_MB = 3'b010;
  localparam logic [2:0] E_AL = 3'b111;
  localparam logic [2:0] E_MR = 3'b011;

  // ID/EX fields {rs, rt, rs_valid, rt_valid, ex_wr, ex_reg_write, ex_mem_read}
  localparam logic [12:0] NO_LU  = 13'd0;
  localparam logic [12:0] LU_RT  = {3'd5, 3'd3, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1};
  localparam logic [12:0] LU_RS  = {3'd3, 3'd6, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1};
  localparam logic [12:0] INV_RT = {3'd1, 3'd3, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1};
  localparam logic [12:0] NO_RD  = {3'd3, 3'd3, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0};

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [7:0] obs_a();
    return {if_a.pc_write_en, if_a.if_id_write_en, if_a.if_id_flush,
            if_a.zero_control_signals, if_a.pipe_hold, if_a.halted, state_a};
  endfunction

  function automatic logic [7:0] obs_b();
    return {if_b.pc_write_en, if_b.if_id_write_en, if_b.if_id_flush,
            if_b.zero_control_signals, if_b.pipe_hold, if_b.halted, state_b};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic set_inputs(input logic [2:0] ev, input logic [12:0] ix);
    {if_a.halt_in, if_a.mem_busy, if_a.redirect} = ev;
    {if_a.id_rs, if_a.id_rt, if_a.id_rs_valid, if_a.id_rt_valid,
     if_a.ex_write_reg, if_a.ex_reg_write, if_a.ex_mem_read} = ix;
  endtask

  task automatic drive(input logic [2:0] ev, input logic [12:0] ix, input logic [7:0] exp);
    @(negedge clk);
    set_inputs(ev, ix);
    exp_q.push_back(exp);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    set_inputs(E_NO, NO_LU);
    rst = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [7:0] e;
    set_inputs(E_NO, NO_LU);
    rst = 1'b0;
    exp_q.push_back({O_RUN, S_RUN});
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (obs_a() !== e) begin n_fail++; $display("FAIL reset_out_a: got %b expected %b", obs_a(), e); end
    n_cmp++;
    if (obs_b() !== e) begin n_fail++; $display("FAIL reset_out_b: got %b expected %b", obs_b(), e); end
    n_cmp++;
    if (sc_a !== 4'd0 || sc_b !== 16'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d/%0d expected 0/0", sc_a, sc_b);
    end
  endtask

  task automatic test_load_use();
    logic [2:0]  ev[2] = '{E_NO, E_NO};
    logic [12:0] ix[2] = '{LU_RT, NO_LU};
    logic [7:0]  ex[2] = '{{O_BUB, S_RUN}, {O_RUN, S_RUN}};
    logic [7:0]  e;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      drive(ev[i], ix[i], ex[i]);
      #2;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_a() !== e) begin n_fail++; $display("FAIL load_use step %0d: got %b expected %b", i, obs_a(), e); end
    end
    n_cmp++;
    if (sc_a !== 4'd1 || sc_b !== 16'd1) begin
      n_fail++; $display("FAIL load_use_count: got %0d/%0d expected 1/1", sc_a, sc_b);
    end
  endtask

  task automatic test_invalid_source();
    logic [12:0] ix[3] = '{INV_RT, NO_RD, NO_LU};
    logic [7:0]  e;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(E_NO, ix[i], {O_RUN, S_RUN});
      #2;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_a() !== e) begin n_fail++; $display("FAIL invalid_source step %0d: got %b expected %b", i, obs_a(), e); end
    end
    n_cmp++;
    if (sc_a !== 4'd0) begin n_fail++; $display("FAIL invalid_source_count: got %0d expected 0", sc_a); end
  endtask

  task automatic test_back_to_back();
    logic [12:0] ix[3] = '{LU_RT, LU_RS, NO_LU};
    logic [7:0]  ex[3] = '{{O_BUB, S_RUN}, {O_BUB, S_RUN}, {O_RUN, S_RUN}};
    logic [7:0]  e;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(E_NO, ix[i], ex[i]);
      #2;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_a() !== e) begin n_fail++; $display("FAIL back_to_back step %0d: got %b expected %b", i, obs_a(), e); end
    end
    n_cmp++;
    if (sc_a !== 4'd2) begin n_fail++; $display("FAIL back_to_back_count: got %0d expected 2", sc_a); end
  endtask

  task automatic test_redirect();
    logic [2:0]  ev[4]  = '{E_RD, E_NO, E_NO, E_NO};
    logic [12:0] ix[4]  = '{NO_LU, LU_RT, NO_LU, NO_LU};
    logic [7:0]  ex[4]  = '{{O_FLS, S_RUN}, {O_FLS, S_FLS}, {O_FLS, S_FLS}, {O_RUN, S_RUN}};
    logic [7:0]  exb[4] = '{{O_FLS, S_RUN}, {O_BUB, S_RUN}, {O_RUN, S_RUN}, {O_RUN, S_RUN}};
    logic [7:0]  e;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(ev[i], ix[i], ex[i]);
      #2;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_a() !== e) begin n_fail++; $display("FAIL redirect step %0d: got %b expected %b", i, obs_a(), e); end
      n_cmp++;
      if (obs_b() !== exb[i]) begin n_fail++; $display("FAIL redirect_len1 step %0d: got %b expected %b", i, obs_b(), exb[i]); end
    end
  endtask

  task automatic test_flush_mem_busy();
    logic [2:0] ev[8] = '{E_RD, E_NO, E_MB, E_MB, E_MB, E_MB, E_NO, E_NO};
    logic [7:0] ex[8] = '{{O_FLS, S_RUN}, {O_FLS, S_FLS}, {O_HLD, S_FLS}, {O_HLD, S_FLS},
                          {O_HLD, S_FLS}, {O_HLD, S_FLS}, {O_FLS, S_FLS}, {O_RUN, S_RUN}};
    logic [7:0] e;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive(ev[i], NO_LU, ex[i]);
      #2;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_a() !== e) begin n_fail++; $display("FAIL flush_mem_busy step %0d: got %b expected %b", i, obs_a(), e); end
    end
    n_cmp++;
    if (sc_a !== 4'd4) begin n_fail++; $display("FAIL flush_mem_busy_count: got %0d expected 4", sc_a); end
  endtask

  task automatic test_flush_redirect();
    logic [2:0] ev[6] = '{E_RD, E_NO, E_RD, E_NO, E_NO, E_NO};
    logic [7:0] ex[6] = '{{O_FLS, S_RUN}, {O_FLS, S_FLS}, {O_FLS, S_FLS},
                          {O_FLS, S_FLS}, {O_FLS, S_FLS}, {O_RUN, S_RUN}};
    logic [7:0] e;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive(ev[i], NO_LU, ex[i]);
      #2;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_a() !== e) begin n_fail++; $display("FAIL flush_redirect step %0d: got %b expected %b", i, obs_a(), e); end
    end
  endtask

  task automatic test_memwait();
    logic [2:0]  ev[9] = '{E_MB, E_MB, E_NO, E_NO, E_MB, E_RD, E_NO, E_NO, E_NO};
    logic [12:0] ix[9] = '{NO_LU, NO_LU, LU_RT, NO_LU, NO_LU, NO_LU, NO_LU, NO_LU, NO_LU};
    logic [7:0]  ex[9] = '{{O_HLD, S_RUN}, {O_HLD, S_MW}, {O_BUB, S_MW}, {O_RUN, S_RUN},
                           {O_HLD, S_RUN}, {O_FLS, S_MW}, {O_FLS, S_FLS}, {O_FLS, S_FLS},
                           {O_RUN, S_RUN}};
    logic [7:0]  e;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      drive(ev[i], ix[i], ex[i]);
      #2;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_a() !== e) begin n_fail++; $display("FAIL memwait step %0d: got %b expected %b", i, obs_a(), e); end
    end
    n_cmp++;
    if (sc_a !== 4'd4) begin n_fail++; $display("FAIL memwait_count: got %0d expected 4", sc_a); end
  endtask

  task automatic test_priority();
    logic [2:0]  ev[6] = '{E_MR, E_RD, E_NO, E_NO, E_RD, E_NO};
    logic [12:0] ix[6] = '{LU_RT, LU_RT, LU_RT, NO_LU, LU_RT, NO_LU};
    logic [7:0]  ex[6] = '{{O_HLD, S_RUN}, {O_FLS, S_MW}, {O_FLS, S_FLS},
                           {O_FLS, S_FLS}, {O_FLS, S_RUN}, {O_FLS, S_FLS}};
    logic [7:0]  e;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive(ev[i], ix[i], ex[i]);
      #2;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_a() !== e) begin n_fail++; $display("FAIL priority step %0d: got %b expected %b", i, obs_a(), e); end
    end
  endtask

  task automatic test_reset_mid_state();
    logic [2:0] ev[2] = '{E_RD, E_MB};
    logic [7:0] ex[2] = '{{O_FLS, S_RUN}, {O_HLD, S_RUN}};
    logic [7:0] e;
    for (int i = 0; i < 2; i++) begin
      apply_reset();
      drive(ev[i], NO_LU, ex[i]);
      #2;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_a() !== e) begin n_fail++; $display("FAIL mid_state_enter %0d: got %b expected %b", i, obs_a(), e); end
      @(negedge clk);
      set_inputs(E_NO, NO_LU);
      #1 rst = 1'b0;
      #1;
      n_cmp++;
      if (obs_a() !== {O_RUN, S_RUN} || sc_a !== 4'd0) begin
        n_fail++; $display("FAIL mid_state_reset %0d: got %b/%0d expected %b/0", i, obs_a(), sc_a, {O_RUN, S_RUN});
      end
      @(negedge clk);
      rst = 1'b1;
      drive(E_NO, NO_LU, {O_RUN, S_RUN});
      #2;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_a() !== e) begin n_fail++; $display("FAIL mid_state_residue %0d: got %b expected %b", i, obs_a(), e); end
    end
  endtask

  task automatic test_halt();
    logic [2:0]  ev[6] = '{E_NO, E_AL, E_NO, E_MB, E_RD, E_NO};
    logic [12:0] ix[6] = '{LU_RT, NO_LU, NO_LU, NO_LU, LU_RT, NO_LU};
    logic [7:0]  ex[6] = '{{O_BUB, S_RUN}, {O_HLT, S_RUN}, {O_HLT, S_HLT},
                           {O_HLT, S_HLT}, {O_HLT, S_HLT}, {O_HLT, S_HLT}};
    logic [7:0]  e;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive(ev[i], ix[i], ex[i]);
      #2;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_a() !== e) begin n_fail++; $display("FAIL halt step %0d: got %b expected %b", i, obs_a(), e); end
    end
    // one stall from the bubble, one from the halt cycle in RUN, none in HALT
    n_cmp++;
    if (sc_a !== 4'd2 || sc_b !== 16'd2) begin
      n_fail++; $display("FAIL halt_count: got %0d/%0d expected 2/2", sc_a, sc_b);
    end
    set_inputs(E_NO, NO_LU);
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if (state_a !== S_RUN || sc_a !== 4'd0 || sc_b !== 16'd0 || obs_a() !== {O_RUN, S_RUN}) begin
      n_fail++; $display("FAIL halt_async_reset: got state %0d count %0d out %b expected 0 0 %b",
                         state_a, sc_a, obs_a(), {O_RUN, S_RUN});
    end
    @(negedge clk);
    rst = 1'b1;
    drive(E_NO, NO_LU, {O_RUN, S_RUN});
    #2;
    e = exp_q.pop_front();
    n_cmp++;
    if (obs_a() !== e) begin n_fail++; $display("FAIL halt_release: got %b expected %b", obs_a(), e); end
  endtask

  task automatic test_saturation();
    logic [7:0] e;
    logic [3:0] exp_sc;
    apply_reset();
    for (int i = 0; i < 22; i++) begin
      drive(E_MB, NO_LU, {O_HLD, (i == 0) ? S_RUN : S_MW});
      #2;
      e = exp_q.pop_front();
      exp_sc = (i > 15) ? 4'd15 : 4'(i);
      n_cmp++;
      if (obs_a() !== e) begin n_fail++; $display("FAIL saturation_out step %0d: got %b expected %b", i, obs_a(), e); end
      n_cmp++;
      if (sc_a !== exp_sc || sc_b !== 16'(i)) begin
        n_fail++; $display("FAIL saturation_count step %0d: got %0d/%0d expected %0d/%0d", i, sc_a, sc_b, exp_sc, i);
      end
    end
  endtask

  task automatic test_random_load_use();
    logic [7:0]  e;
    logic [2:0]  rs, rt, wr;
    logic        rsv, rtv, rw, mr, lu;
    int          stalls = 0;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      rs  = 3'($urandom_range(0, 3));
      rt  = 3'($urandom_range(0, 3));
      wr  = 3'($urandom_range(0, 3));
      rsv = 1'($urandom_range(0, 1));
      rtv = 1'($urandom_range(0, 1));
      rw  = ($urandom_range(0, 3) != 0);
      mr  = ($urandom_range(0, 3) != 0);
      lu  = mr & rw & ((rsv & (rs == wr)) | (rtv & (rt == wr)));
      drive(E_NO, {rs, rt, rsv, rtv, wr, rw, mr}, lu ? {O_BUB, S_RUN} : {O_RUN, S_RUN});
      if (lu) stalls++;
      #2;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_a() !== e) begin n_fail++; $display("FAIL random_load_use step %0d: got %b expected %b", i, obs_a(), e); end
    end
    @(negedge clk);
    set_inputs(E_NO, NO_LU);
    #1;
    n_cmp++;
    if (sc_a !== ((stalls > 15) ? 4'd15 : 4'(stalls)) || sc_b !== 16'(stalls)) begin
      n_fail++; $display("FAIL random_load_use_count: got %0d/%0d expected %0d", sc_a, sc_b, stalls);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_load_use();
    test_invalid_source();
    test_back_to_back();
    test_redirect();
    test_flush_mem_busy();
    test_flush_redirect();
    test_memwait();
    test_priority();
    test_reset_mid_state();
    test_halt();
    test_saturation();
    test_random_load_use();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
